// File: rtl/lab_pkg.sv
// Shared types and screen geometry for the square outline plotter.
// Optional clear phase is controlled by SQUARE_OUTLINE_CLEAR_EN.
package lab_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        TOP,
        BOTTOM,
        LEFT,
        RIGHT,
        FINISH
    } state_e;

    // Zero-extend an unsigned screen quantity into the signed corner domain.
    function automatic logic signed [9:0] to_s10(input logic [7:0] v);
        return signed'({2'b00, v});
    endfunction

    function automatic logic on_screen(input logic signed [9:0] px,
                                       input logic signed [9:0] py);
        return !px[9] && (px < 10'(SCREEN_W)) && !py[9] && (py < 10'(SCREEN_H));
    endfunction

endpackage

// File: rtl/square_outline_clear_scan.sv
// Raster scanner for the clear phase: x fastest across the screen, then y.
// Counters sit at the origin whenever the scan is not enabled.
module clear_scan
    import lab_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic       last_o
);

    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == 8'(SCREEN_W - 1)) && (y_q == 7'(SCREEN_H - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (!en_i) begin
            x_d = '0;
            y_d = '0;
        end else if (x_q == 8'(SCREEN_W - 1)) begin
            x_d = '0;
            y_d = last_o ? '0 : y_q + 7'd1;
        end else begin
            x_d = x_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/square_outline.sv
// Square outline plotter: optional screen clear, then walks the four edges one pixel per cycle.
// Define SQUARE_OUTLINE_CLEAR_EN to include the clear phase.
module square_outline
    import lab_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] diameter,
    input  logic [2:0] colour,
    input  logic       forced_early_clear,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    state_e            state_q, state_d;
    logic [7:0]        cx_q, cx_d;
    logic [6:0]        cy_q, cy_d;
    logic [6:0]        r_q, r_d;
    logic [2:0]        col_q, col_d;
    logic signed [9:0] cnt_q, cnt_d;
    logic signed [9:0] x0, x1, y0, y1, x0_in;
    logic signed [9:0] px, py;
    logic              draw;
    logic              unused_ok;

    // Corners are signed so edges hanging off the screen never wrap onto it.
    assign x0    = to_s10(cx_q) - to_s10({1'b0, r_q});
    assign x1    = to_s10(cx_q) + to_s10({1'b0, r_q});
    assign y0    = to_s10({1'b0, cy_q}) - to_s10({1'b0, r_q});
    assign y1    = to_s10({1'b0, cy_q}) + to_s10({1'b0, r_q});
    assign x0_in = to_s10(centre_x) - to_s10({1'b0, diameter[7:1]});

`ifdef SQUARE_OUTLINE_CLEAR_EN
    logic       clr_en;
    logic [7:0] scan_x;
    logic [6:0] scan_y;
    logic       scan_last;

    clear_scan u_clear_scan (
        .clk    (clk),
        .rst    (rst),
        .en_i   (clr_en),
        .x_o    (scan_x),
        .y_o    (scan_y),
        .last_o (scan_last)
    );

    assign unused_ok = diameter[0];
`else
    assign unused_ok = diameter[0] ^ forced_early_clear;
`endif

    always_comb begin
        state_d    = state_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        r_d        = r_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        px         = '0;
        py         = '0;
        draw       = 1'b0;
        done       = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
`ifdef SQUARE_OUTLINE_CLEAR_EN
        clr_en     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    cx_d    = centre_x;
                    cy_d    = centre_y;
                    r_d     = diameter[7:1];
                    col_d   = colour;
                    cnt_d   = x0_in;
                    state_d = TOP;
`ifdef SQUARE_OUTLINE_CLEAR_EN
                    if (!forced_early_clear) state_d = CLEAR;
`endif
                end
            end
`ifdef SQUARE_OUTLINE_CLEAR_EN
            CLEAR: begin
                clr_en   = 1'b1;
                vga_x    = scan_x;
                vga_y    = scan_y;
                vga_plot = 1'b1;
                if (scan_last) begin
                    cnt_d   = x0;
                    state_d = TOP;
                end
            end
`endif
            TOP: begin
                px   = cnt_q;
                py   = y0;
                draw = 1'b1;
                if (cnt_q == x1) begin
                    cnt_d   = x0;
                    state_d = (r_q == '0) ? FINISH : BOTTOM;
                end else begin
                    cnt_d = cnt_q + 10'sd1;
                end
            end
            BOTTOM: begin
                px   = cnt_q;
                py   = y1;
                draw = 1'b1;
                if (cnt_q == x1) begin
                    cnt_d   = y0 + 10'sd1;
                    state_d = LEFT;
                end else begin
                    cnt_d = cnt_q + 10'sd1;
                end
            end
            // Side edges skip the corner rows already drawn by TOP/BOTTOM.
            LEFT: begin
                px   = x0;
                py   = cnt_q;
                draw = 1'b1;
                if (cnt_q == y1 - 10'sd1) begin
                    cnt_d   = y0 + 10'sd1;
                    state_d = RIGHT;
                end else begin
                    cnt_d = cnt_q + 10'sd1;
                end
            end
            RIGHT: begin
                px   = x1;
                py   = cnt_q;
                draw = 1'b1;
                if (cnt_q == y1 - 10'sd1) state_d = FINISH;
                else                      cnt_d   = cnt_q + 10'sd1;
            end
            FINISH: begin
                done = 1'b1;
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (draw) begin
            vga_x      = px[7:0];
            vga_y      = py[6:0];
            vga_colour = col_q;
            vga_plot   = on_screen(px, py);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            r_q     <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            r_q     <= r_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_square_outline.sv
// Directed bench for square_outline: expected pixel stream queued per request, popped on each plot.
// Expectations follow SQUARE_OUTLINE_CLEAR_EN the same way the design does.
module tb_square_outline;
    import lab_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] diameter;
    logic [2:0] colour;
    logic       forced_early_clear;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int checks = 0;
    int errors = 0;
    int unsigned exp_q[$];

    square_outline dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .centre_x           (centre_x),
        .centre_y           (centre_y),
        .diameter           (diameter),
        .colour             (colour),
        .forced_early_clear (forced_early_clear),
        .done               (done),
        .vga_x              (vga_x),
        .vga_y              (vga_y),
        .vga_colour         (vga_colour),
        .vga_plot           (vga_plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_px(input int x, input int y, input int c);
        if (x >= 0 && x < 160 && y >= 0 && y < 120)
            exp_q.push_back(unsigned'((x << 10) | (y << 3) | c));
    endtask

    function automatic int unsigned obs_px();
        return unsigned'({14'd0, vga_x, vga_y, vga_colour});
    endfunction

    task automatic run_req(input int cx, input int cy, input int d, input int col,
                           input bit fec, input int hold);
        int r;
        int n;
        int cyc;
        r = d / 2;
        n = 0;
        exp_q.delete();
`ifdef SQUARE_OUTLINE_CLEAR_EN
        if (!fec) begin
            for (int y = 0; y < 120; y++)
                for (int x = 0; x < 160; x++) push_px(x, y, 0);
            n += 19200;
        end
`endif
        if (r == 0) begin
            push_px(cx, cy, col);
            n += 1;
        end else begin
            for (int x = cx - r; x <= cx + r; x++) push_px(x, cy - r, col);
            for (int x = cx - r; x <= cx + r; x++) push_px(x, cy + r, col);
            for (int y = cy - r + 1; y <= cy + r - 1; y++) push_px(cx - r, y, col);
            for (int y = cy - r + 1; y <= cy + r - 1; y++) push_px(cx + r, y, col);
            n += 8 * r;
        end

        @(posedge clk); #1;
        centre_x           = 8'(cx);
        centre_y           = 7'(cy);
        diameter           = 8'(d);
        colour             = 3'(col);
        forced_early_clear = fec;
        start              = 1'b1;

        cyc = 0;
        while (cyc < 25000) begin
            @(negedge clk);
            if (done) break;
            if (vga_plot) begin
                if (exp_q.size() == 0) chk("extra_plot", obs_px(), 0);
                else                   chk("pixel", obs_px(), exp_q.pop_front());
            end
            cyc++;
        end
        chk("done_seen", 32'(done), 1);
        chk("cycle_count", cyc, n + 1);
        chk("plots_left", exp_q.size(), 0);

        repeat (hold) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 1);
            chk("hold_noplot", 32'(vga_plot), 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_release", 32'(done), 0);
        chk("idle_after_release", 32'(dut.state_q == IDLE), 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_done"},   32'(done), 0);
        chk({tag, "_plot"},   32'(vga_plot), 0);
        chk({tag, "_x"},      32'(vga_x), 0);
        chk({tag, "_y"},      32'(vga_y), 0);
        chk({tag, "_colour"}, 32'(vga_colour), 0);
    endtask

    initial begin
        rst                = 1'b1;
        start              = 1'b0;
        centre_x           = '0;
        centre_y           = '0;
        diameter           = '0;
        colour             = '0;
        forced_early_clear = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        chk("reset_state", 32'(dut.state_q == IDLE), 1);
        rst = 1'b0;

        // Centred square (clear phase included when the build has it).
        run_req(80, 60, 80, 2, 1'b0, 0);
        // Degenerate r=0: single pixel.
        run_req(10, 5, 0, 5, 1'b1, 0);
        // Square hanging off the top-left corner: heavy clipping.
        run_req(0, 0, 20, 3, 1'b1, 0);
        // Start held after done.
        run_req(30, 30, 6, 7, 1'b1, 15);
        // Odd diameter behaves as the even one below it.
        run_req(80, 60, 81, 2, 1'b1, 0);
        // Clipping on the bottom-right side.
        run_req(159, 119, 10, 1, 1'b1, 0);

        // Reset during TOP aborts the request.
        @(posedge clk); #1;
        centre_x           = 8'd80;
        centre_y           = 7'd60;
        diameter           = 8'd80;
        colour             = 3'd4;
        forced_early_clear = 1'b1;
        start              = 1'b1;
        repeat (10) @(negedge clk);
        chk("mid_top_plot", 32'(vga_plot), 1);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk_outputs_zero("abort");
        chk("abort_state", 32'(dut.state_q == IDLE), 1);
        rst = 1'b0;
        run_req(20, 15, 8, 6, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/square_outline.md
SQUARE_OUTLINE -- requirements
Module: square_outline

Interface
REQ-001 SHALL provide: clk  input  1  system clock; every register updates on the rising edge.
REQ-002 SHALL provide: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL provide: start  input  1  request; level-held by the initiator until done is seen.
REQ-004 SHALL provide: centre_x  input  8  centre column, 0..159.
REQ-005 SHALL provide: centre_y  input  7  centre row, 0..119.
REQ-006 SHALL provide: diameter  input  8  outline side length; LSB is ignored.
REQ-007 SHALL provide: colour  input  3  outline colour.
REQ-008 SHALL provide: forced_early_clear  input  1  skip the clear phase for this request.
REQ-009 SHALL provide: done  output  1  request complete.
REQ-010 SHALL provide: vga_x  output  8, vga_y  output  7, vga_colour  output  3, vga_plot  output  1  pixel write port.

Function
REQ-011 FSM states SHALL be IDLE, CLEAR, TOP, BOTTOM, LEFT, RIGHT, FINISH.
REQ-012 In IDLE with start=1, the block SHALL latch centre_x, centre_y, r=diameter[7:1], colour and forced_early_clear, then move to CLEAR next cycle (TOP if latched forced_early_clear=1); inputs SHALL be ignored outside IDLE.
REQ-013 CLEAR SHALL plot colour 0 to all 19200 pixels, one per cycle, x fastest (x 0..159, then y 0..119), then enter TOP.
REQ-014 Corners SHALL be computed in signed 10-bit: x0=cx-r, x1=cx+r, y0=cy-r, y1=cy+r; no wrap-around.
REQ-015 TOP SHALL visit x0..x1 at y0; BOTTOM x0..x1 at y1; LEFT y0+1..y1-1 at x0; RIGHT y0+1..y1-1 at x1; one pixel per cycle, vga_colour=latched colour.
REQ-016 A visited pixel outside 0..159 x 0..119 SHALL consume its cycle with vga_plot=0; vga_x/vga_y then carry the low bits of the coordinate.
REQ-017 Outline phase SHALL take exactly 8r cycles for r>=1; for r=0 it SHALL plot only (cx,cy) once in TOP and go to FINISH.
REQ-018 In FINISH done SHALL be 1 and vga_plot 0; done SHALL stay 1 while start=1 and return to IDLE (done=0) the cycle after start is seen low.
REQ-019 vga_plot SHALL be 0 in IDLE and FINISH; a new request SHALL require start to have been low for at least one cycle.

Reset
REQ-020 rst=1 SHALL force IDLE next edge from any state, aborting any request mid-draw.
REQ-021 After reset done, vga_plot, vga_x, vga_y and vga_colour SHALL all be 0.
REQ-022 A start held high through reset release SHALL be accepted as a new request on the first cycle in IDLE.

Configuration
REQ-023 With SQUARE_OUTLINE_CLEAR_EN defined, CLEAR SHALL exist as in REQ-013.
REQ-024 Without SQUARE_OUTLINE_CLEAR_EN, CLEAR SHALL be omitted, IDLE SHALL go directly to TOP, and forced_early_clear SHALL be ignored.

Structure
REQ-025 The FSM state enum and the constants SCREEN_W=160 and SCREEN_H=120 SHALL reside in lab_pkg.
REQ-026 The raster scan for CLEAR SHALL be one sub-module, clear_scan (enable, x/y counters, last flag); edge walking and clipping SHALL stay in square_outline.

Verification
REQ-027 cx=80, cy=60, d=80, colour=2, clear enabled -> 19200 black plots, then 320 outline plots, corners (40,20) and (120,100), done asserted.
REQ-028 d=0, cx=10, cy=5, forced_early_clear=1 -> exactly one plot at (10,5), then done.
REQ-029 cx=0, cy=0, d=20 -> 80 outline cycles with plots only at x,y in 0..10 and no out-of-range plot.
REQ-030 Keep start=1 for 15 cycles after done -> done held high with no plots; start low -> IDLE with done=0 the next cycle.
REQ-031 Assert rst mid-TOP -> next cycle: all outputs 0 and state IDLE; a fresh request then completes correctly.
REQ-032 d=81 -> identical pixel stream to d=80.
